// File: rtl/slc3_mem_pkg.sv
// Shared definitions for the SLC-3 memory path: SRAM geometry and the
// access sequencer's state encoding.
package slc3_mem_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD
  } sram_state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Sequences one asynchronous SRAM access per request: address/data setup,
// WAIT_CYCLES access cycles, hold, then a one-cycle done pulse.
module sram_ctrl
  import slc3_mem_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = SRAM_DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] Data_out,
  output logic              Data_drive,
  input  logic [DATA_W-1:0] Data_in
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  sram_state_t state, state_nxt;
  logic [3:0]  cnt;
  logic        wr_p0;
  logic [1:0]  be_p0;

  logic        sel_wr;
  logic [1:0]  sel_be;
  logic        active_nxt;
  logic        ce_nxt, ub_nxt, lb_nxt, oe_nxt, we_nxt, drive_nxt, done_nxt;

  assign ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state, so the request fields must
  // come straight from the inputs on the accepting edge.
  always_comb begin
    sel_wr     = (state == IDLE) ? wr : wr_p0;
    sel_be     = (state == IDLE) ? be : be_p0;
    active_nxt = (state_nxt != IDLE);
    ce_nxt     = ~active_nxt;
    ub_nxt     = active_nxt ? ~sel_be[1] : 1'b1;
    lb_nxt     = active_nxt ? ~sel_be[0] : 1'b1;
    we_nxt     = ~(sel_wr && (state_nxt == ACCESS));
    oe_nxt     = ~(!sel_wr && ((state_nxt == SETUP) || (state_nxt == ACCESS)));
    drive_nxt  = sel_wr && active_nxt;
    done_nxt   = (state_nxt == HOLD);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      wr_p0      <= 1'b0;
      be_p0      <= 2'b00;
      CE         <= 1'b1;
      UB         <= 1'b1;
      LB         <= 1'b1;
      OE         <= 1'b1;
      WE         <= 1'b1;
      A          <= '0;
      Data_out   <= '0;
      Data_drive <= 1'b0;
      rdata      <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      CE         <= ce_nxt;
      UB         <= ub_nxt;
      LB         <= lb_nxt;
      OE         <= oe_nxt;
      WE         <= we_nxt;
      Data_drive <= drive_nxt;
      done       <= done_nxt;
      if (state == IDLE && req) begin
        wr_p0 <= wr;
        be_p0 <= be;
        A     <= addr;
        cnt   <= CNT_LOAD;
        if (wr) Data_out <= wdata;
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Read data is sampled on the edge that ends the last access cycle.
      if (state == ACCESS && cnt == 4'd0 && !wr_p0) rdata <= Data_in;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: an SRAM pin model, a word-level reference
// memory, directed scenarios and a randomized access stream.
module tb_sram_ctrl;
  import slc3_mem_pkg::*;

  localparam int AW   = 20;
  localparam int DW   = 16;
  localparam int WAIT = 2;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          req, wr;
  logic [1:0]    be;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready, done;
  logic [DW-1:0] rdata;
  logic          CE, UB, LB, OE, WE;
  logic [AW-1:0] A;
  logic [DW-1:0] Data_out;
  logic          Data_drive;
  logic [DW-1:0] Data_in;

  sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WAIT)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .wr(wr), .be(be), .addr(addr),
    .wdata(wdata), .ready(ready), .done(done), .rdata(rdata), .CE(CE),
    .UB(UB), .LB(LB), .OE(OE), .WE(WE), .A(A), .Data_out(Data_out),
    .Data_drive(Data_drive), .Data_in(Data_in)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // SRAM pin model, indexed by the low address byte.
  logic [15:0] mem [0:255];
  assign Data_in = (!CE && !OE && !Data_drive) ? mem[A[7:0]] : 16'hDEAD;
  always @(posedge Clk) begin
    if (!CE && !WE && Data_drive) begin
      if (!UB) mem[A[7:0]][15:8] = Data_out[15:8];
      if (!LB) mem[A[7:0]][7:0]  = Data_out[7:0];
    end
  end

  // Reference memory and scoreboard.
  logic [15:0] ref_mem [0:255];
  logic [15:0] last_rd = 16'h0000;

  typedef struct {
    int          exp_cyc;
    bit          is_rd;
    logic [15:0] exp_rdata;
  } txn_t;
  txn_t sb[$];

  always @(negedge Clk) begin
    txn_t t;
    if (done) begin
      if (sb.size() == 0) check("spurious_done", 32'd1, 32'd0);
      else begin
        t = sb.pop_front();
        check("done_cycle", cyc, t.exp_cyc);
        if (t.is_rd) begin
          check("rdata", {16'h0, rdata}, {16'h0, t.exp_rdata});
          last_rd = t.exp_rdata;
        end else begin
          check("rdata_kept", {16'h0, rdata}, {16'h0, last_rd});
        end
      end
    end
  end

  // While WE is low: chip selected, data driven, address/data unchanged,
  // and CE was already low in the previous cycle.
  logic          p_ce = 1'b1;
  logic [AW-1:0] p_a;
  logic [DW-1:0] p_d;
  always @(negedge Clk) begin
    if (WE === 1'b0)
      check("we_window", {27'h0, CE, A == p_a, Data_out == p_d, Data_drive, p_ce},
            {27'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
    p_ce = CE;
    p_a  = A;
    p_d  = Data_out;
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge Clk);
    while (ready !== 1'b1 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (ready !== 1'b1) check("ready_timeout", {31'h0, ready}, 32'd1);
  endtask

  task automatic issue(input bit w, input logic [1:0] b, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit wave);
    txn_t t;
    int   k;
    wait_ready();
    req = 1'b1; wr = w; be = b; addr = a; wdata = d;
    @(posedge Clk); #1;
    req = 1'b0; wr = ~w; be = ~b; addr = ~a; wdata = ~d;
    k = cyc;
    t.exp_cyc = k + WAIT + 1;
    t.is_rd   = !w;
    t.exp_rdata = ref_mem[a[7:0]];
    if (w) begin
      if (b[1]) ref_mem[a[7:0]][15:8] = d[15:8];
      if (b[0]) ref_mem[a[7:0]][7:0]  = d[7:0];
    end
    sb.push_back(t);
    if (wave) begin
      for (int n = 1; n <= WAIT + 3; n++) begin
        bit in_acc;
        @(negedge Clk);
        in_acc = (n <= WAIT + 2);
        check($sformatf("strobes_c%0d", n), {27'h0, CE, WE, OE, Data_drive, 1'b0},
              {27'h0, !in_acc, !(w && n >= 2 && n <= WAIT + 1),
               !(!w && n <= WAIT + 1), w && in_acc, 1'b0});
        if (in_acc) begin
          check($sformatf("addr_c%0d", n), {12'h0, A}, {12'h0, a});
          check($sformatf("bytes_c%0d", n), {30'h0, UB, LB}, {30'h0, ~b[1], ~b[0]});
          if (w) check($sformatf("dout_c%0d", n), {16'h0, Data_out}, {16'h0, d});
        end
      end
    end
  endtask

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'(i * 257) ^ 16'h3C3C;
      ref_mem[i] = 16'(i * 257) ^ 16'h3C3C;
    end
    Reset = 1'b1; req = 1'b0; wr = 1'b0; be = 2'b00; addr = '0; wdata = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("reset_ready", {31'h0, ready}, 32'd1);
    check("reset_strobes", {27'h0, CE, UB, LB, OE, WE}, {27'h0, 5'b11111});
    check("reset_outs", {A[15:0], rdata}, 32'h0);
    check("reset_ctl", {30'h0, done, Data_drive}, 32'h0);

    // Full-word write then read back.
    issue(1'b1, 2'b11, 20'h00042, 16'hBEEF, 1'b1);
    issue(1'b0, 2'b11, 20'h00042, 16'h0000, 1'b1);

    // Upper-byte write over a zeroed cell.
    mem[8'hA0] = 16'h0000;
    ref_mem[8'hA0] = 16'h0000;
    issue(1'b1, 2'b10, 20'h000A0, 16'h12AB, 1'b1);
    issue(1'b0, 2'b11, 20'h000A0, 16'h0000, 1'b0);

    // A request while busy is dropped; the next one after HOLD is taken.
    issue(1'b1, 2'b11, 20'h00042, 16'h5A5A, 1'b0);
    @(posedge Clk); #1;
    req = 1'b1; wr = 1'b0; be = 2'b11; addr = 20'h00001;
    @(posedge Clk); #1;
    req = 1'b0;
    issue(1'b0, 2'b01, 20'h00042, 16'h0000, 1'b0);

    // Reset during the access phase of a write.
    issue(1'b1, 2'b11, 20'hF0080, 16'hA5A5, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    sb.delete();
    last_rd = 16'h0000;
    check("abort_strobes", {29'h0, WE, CE, Data_drive}, {29'h0, 3'b110});
    check("abort_done", {31'h0, done}, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    check("abort_ready", {31'h0, ready}, 32'd1);
    check("abort_rdata", {16'h0, rdata}, 32'h0);

    // Randomized stream away from the abort and byte-test cells.
    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      issue(r[31], r[30:29], {r[19:8], 1'b0, r[6:0]}, 16'($urandom), 1'b0);
      repeat ($urandom % 3) @(negedge Clk);
    end

    repeat (10) @(negedge Clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Timing stage between the CPU/Mem2IO memory request path and the external 1M x 16 asynchronous SRAM pins (CE, UB, LB, OE, WE, A, data).
- Converts a single-cycle request pulse into a correctly sequenced SRAM access: setup, a programmable number of access wait states, and hold.
- Returns read data with a one-cycle done pulse.
- Sits directly downstream of the CPU/Mem2IO request logic in the SLC-3 top level.

Parameters:
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width.
- WAIT_CYCLES, 2, number of ACCESS cycles; legal range 1..15.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- req  in  1  request pulse; sampled only while ready=1.
- wr  in  1  1 = write, 0 = read; sampled with req.
- be  in  2  byte enables {upper, lower}; sampled with req.
- addr  in  ADDR_W  word address; sampled with req.
- wdata  in  DATA_W  write data; sampled with req.
- ready  out  1  controller idle and able to accept req.
- done  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  captured read data.
- CE, UB, LB, OE, WE  out  1 each  SRAM strobes, active-low, registered.
- A  out  ADDR_W  SRAM address, registered.
- Data_out  out  DATA_W  data driven toward SRAM.
- Data_drive  out  1  tristate enable for Data_out; the top level owns the bidirectional pin.
- Data_in  in  DATA_W  data returned from the SRAM pins.

Behaviour:
- Reset and Reset-abort state: applies at any Clk edge with Reset=1, including mid-access.
  - FSM goes to IDLE.
  - CE, UB, LB, OE and WE are all 1.
  - A=0, Data_out=0, Data_drive=0, rdata=0, done=0.
  - An aborted access produces no done pulse.
- FSM states: IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles, down-counter) -> HOLD -> IDLE.
- ready: combinational, equals (state == IDLE). It is 1 in the cycle after Reset deasserts.
- IDLE:
  - req=1 at a Clk edge latches wr, be, addr and wdata.
  - A is loaded and the FSM moves to SETUP. The counter loads WAIT_CYCLES-1.
  - req=0 keeps the FSM in IDLE.
- SETUP:
  - CE=0.
  - UB = ~be[1], LB = ~be[0].
  - Read: OE=0.
  - Write: Data_drive=1, Data_out = latched wdata; WE stays 1 (address setup).
- ACCESS:
  - Signals as in SETUP, plus WE=0 for writes.
  - Counter decrements each cycle; the FSM leaves for HOLD when the counter reaches 0.
  - Read: rdata <= Data_in at the exit edge of the last ACCESS cycle.
- HOLD:
  - CE=0; WE=1, OE=1.
  - Write: Data_drive stays 1 (data hold).
  - done=1 for exactly this cycle. Next edge goes to IDLE.
- Latency: req sampled at edge 0 -> done high in cycle WAIT_CYCLES+2 (cycle 4 for the default).
  - Throughput: one access per WAIT_CYCLES+3 cycles.
  - Back-to-back: the next req is accepted in the cycle after HOLD.
- req while ready=0 is ignored: not queued, no error.
- rdata holds its value until the next read completes. Writes do not alter rdata.
- be=2'b00:
  - Full access sequence runs; UB=LB=1 throughout; done pulses.
  - Write with be=00: WE is still pulsed, but the SRAM ignores it because both byte lanes are disabled.
  - Read with be=00: rdata captures Data_in as-is.
- Partial-byte read (be=01 or 10): rdata captures all 16 bits; the consumer masks.
- A, UB, LB and Data_out are stable from SETUP through HOLD.
  - Address and data never change while WE=0.
  - WE never goes to 0 in the same cycle CE first goes to 0.
- Address range: addr passes through unmodified; there is no wrap or range checking.

Decomposition:
- Shared package slc3_mem_pkg holds:
  - typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} sram_state_t;
  - localparams SRAM_ADDR_W=20 and SRAM_DATA_W=16, which the parameter defaults reference.
- No sub-module. The wait counter is a few lines inside the FSM; a separate module would add ports without adding reuse.

Test Plan:
- Reset held 3 cycles, then released -> ready=1 and all strobes 1; A=0, rdata=0, done=0, Data_drive=0.
- Write with WAIT_CYCLES=2: addr=20'h0_0042, wdata=16'hBEEF, be=11.
  - CE=0 in cycles 1-4; WE=0 only in cycles 2-3.
  - Data_drive=1 in cycles 1-4, with Data_out=BEEF and A=00042 stable.
  - done=1 in cycle 4 only.
- Read of 20'h0_0042 with the SRAM model returning 16'hBEEF.
  - OE=0 in cycles 1-3; done in cycle 4 with rdata=BEEF.
  - Data_drive stays 0 throughout.
- Byte write: be=10, wdata=16'h12AB over an SRAM cell preset to 16'h0000 -> UB=0, LB=1; cell reads back 16'h1200.
- Busy behaviour: second req (read, addr 1) in cycle 2 of a write is ignored (no second done).
  - A req in the first ready cycle after HOLD is accepted; its done arrives 4 cycles later.
- Abort: Reset asserted during ACCESS of a write.
  - Next cycle: WE=CE=1, Data_drive=0; done never pulses.
  - ready=1 after release; rdata unchanged at 0.
